// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared ray tracing types, constants and sequencer state encoding
package ray_pkg;

    // 16.16 signed fixed-point distance / coordinate
    typedef logic signed [31:0] fixed_real;

    typedef struct packed {
        fixed_real x;
        fixed_real y;
        fixed_real z;
    } vector;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color;

    // "No hit yet" distance: largest positive fixed_real
    localparam fixed_real T_MAX = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_TEST   = 3'd3,
        ST_FINISH = 3'd4
    } scan_state_e;

    // Strictly closer: equal distances never replace the earlier (lower index) sphere
    function automatic logic t_closer(input fixed_real t_new, input fixed_real t_best);
        return t_new < t_best;
    endfunction

endpackage

// File: rtl/sphere_hit_scanner.sv
// rtl/sphere_hit_scanner.sv - scans NUM_SPHERES spheres per ray, keeps nearest hit; NEAR_CLIP_EN rejects t <= 0
module sphere_hit_scanner
    import ray_pkg::*;
#(
    parameter int NUM_SPHERES = 8,
    parameter int IDX_W       = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  vector            ray,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] sph_addr,
    output logic             sph_rd,
    input  vector            sph_data,
    output vector            col_sphere,
    output vector            col_ray,
    output fixed_real        col_tbest,
    input  fixed_real        col_tnew,
    input  logic             col_collide,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    output fixed_real        hit_t
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPHERES - 1);

    scan_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    vector            ray_q, ray_d;
    vector            sphere_q, sphere_d;
    fixed_real        tbest_q, tbest_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    fixed_real        hit_t_q, hit_t_d;
    logic             accept;

    // Accept a reported hit only if it is strictly nearer than the best so far
    always_comb begin
        accept = col_collide && t_closer(col_tnew, tbest_q);
`ifdef NEAR_CLIP_EN
        accept = accept && (col_tnew > 32'sd0);
`endif
    end

    // Next-state and datapath updates; every register holds unless its state changes it
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ray_d     = ray_q;
        sphere_d  = sphere_q;
        tbest_d   = tbest_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        hit_t_d   = hit_t_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ray_d     = ray;
                    idx_d     = '0;
                    tbest_d   = T_MAX;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    hit_t_d   = T_MAX;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sphere_d = sph_data;
                state_d  = ST_TEST;
            end
            ST_TEST: begin
                if (accept) begin
                    tbest_d   = col_tnew;
                    hit_t_d   = col_tnew;
                    hit_idx_d = idx_q;
                    hit_d     = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ray_q     <= '0;
            sphere_q  <= '0;
            tbest_q   <= T_MAX;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
            hit_t_q   <= T_MAX;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ray_q     <= ray_d;
            sphere_q  <= sphere_d;
            tbest_q   <= tbest_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
            hit_t_q   <= hit_t_d;
        end
    end

    // Outputs decoded from state or driven straight from registers
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_FINISH);
        sph_rd     = (state_q == ST_FETCH);
        sph_addr   = idx_q;
        col_sphere = sphere_q;
        col_ray    = ray_q;
        col_tbest  = tbest_q;
        hit        = hit_q;
        hit_idx    = hit_idx_q;
        hit_t      = hit_t_q;
    end

endmodule

// File: tb/tb_sphere_hit_scanner.sv
// tb/tb_sphere_hit_scanner.sv - self-checking bench for sphere_hit_scanner with 4 spheres
module tb_sphere_hit_scanner;
    import ray_pkg::*;

    localparam int N = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    vector      ray;
    logic       busy, done, sph_rd;
    logic [1:0] sph_addr, hit_idx;
    vector      sph_data, col_sphere, col_ray;
    fixed_real  col_tbest, col_tnew, hit_t;
    logic       col_collide, hit;

    int checks = 0;
    int errors = 0;

    vector      mem [N];
    logic [3:0] cmask;
    fixed_real  ttab [N];

    sphere_hit_scanner #(.NUM_SPHERES(N), .IDX_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .ray(ray),
        .busy(busy), .done(done), .sph_addr(sph_addr), .sph_rd(sph_rd),
        .sph_data(sph_data), .col_sphere(col_sphere), .col_ray(col_ray),
        .col_tbest(col_tbest), .col_tnew(col_tnew), .col_collide(col_collide),
        .hit(hit), .hit_idx(hit_idx), .hit_t(hit_t)
    );

    always #5 Clk = ~Clk;

    // Sphere memory: one-cycle read latency
    always @(posedge Clk) if (sph_rd) sph_data <= mem[sph_addr];

    // Collision unit stand-in: identifies the sphere by its x tag
    always_comb begin
        col_collide = 1'b0;
        col_tnew    = '0;
        for (int i = 0; i < N; i++) begin
            if (col_sphere.x == fixed_real'(32'h100 + i)) begin
                col_collide = cmask[i];
                col_tnew    = ttab[i];
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vector rvec();
        vector v;
        v.x = $urandom; v.y = $urandom; v.z = $urandom;
        return v;
    endfunction

    // Reference: nearest strictly-closer accepted hit over the sphere list
    task automatic ref_scan(output logic eh, output logic [1:0] ei, output fixed_real et,
                            output fixed_real etb3);
        fixed_real best;
        best = T_MAX; eh = 1'b0; ei = 2'd0; etb3 = T_MAX;
        for (int i = 0; i < N; i++) begin
            logic ok;
            if (i == 3) etb3 = best;
            ok = cmask[i] && (ttab[i] < best);
`ifdef NEAR_CLIP_EN
            ok = ok && (ttab[i] > 0);
`endif
            if (ok) begin best = ttab[i]; eh = 1'b1; ei = 2'(i); end
        end
        et = best;
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            mem[i]   = rvec();
            mem[i].x = fixed_real'(32'h100 + i);
        end
    endtask

    // One full scan with stray start pulses at cycles 4 and 13; then checks all results
    task automatic run_and_check(input string tag);
        vector r0;
        int dcyc, nd;
        logic b1, b14, eh;
        logic [1:0] ei;
        fixed_real tb3, et, etb3;
        vector cray;
        ref_scan(eh, ei, et, etb3);
        @(negedge Clk);
        r0 = rvec(); ray = r0; start = 1'b1;
        @(negedge Clk);
        start = 1'b0; ray = rvec();
        dcyc = -1; nd = 0; b1 = 1'b0; b14 = 1'b1; tb3 = '0; cray = '0;
        for (int c = 1; c <= 18; c++) begin
            if (c > 1) @(negedge Clk);
            if (done) begin nd++; if (dcyc < 0) dcyc = c; end
            if (c == 1) b1 = busy;
            if (c == 14) b14 = busy;
            if (c == 12) begin tb3 = col_tbest; cray = col_ray; end
            start = (c == 4 || c == 13);
        end
        start = 1'b0;
        chk({tag, ".done_cycle"}, 128'(dcyc), 128'(13));
        chk({tag, ".done_count"}, 128'(nd), 128'(1));
        chk({tag, ".busy_c1"}, 128'(b1), 128'(1));
        chk({tag, ".busy_c14"}, 128'(b14), 128'(0));
        chk({tag, ".tbest_idx3"}, 128'(tb3), 128'(etb3));
        chk({tag, ".col_ray"}, 128'(cray), 128'(r0));
        chk({tag, ".hit"}, 128'(hit), 128'(eh));
        chk({tag, ".hit_idx"}, 128'(hit_idx), 128'(ei));
        chk({tag, ".hit_t"}, 128'(hit_t), 128'(et));
    endtask

    typedef struct {
        string      name;
        logic [3:0] cm;
        fixed_real  t0, t1, t2, t3;
        logic       eh;
        logic [1:0] ei;
        fixed_real  et;
    } vec_t;

    vec_t vt [7];

    initial begin
        vt[0] = '{"single_idx2", 4'b0100, 32'sh0010_0000, 32'sh0010_0000, 32'sh0050_0000, 32'sh0010_0000,
                  1'b1, 2'd2, 32'sh0050_0000};
        vt[1] = '{"nearer_later", 4'b1010, 32'sh0001_0000, 32'sh0080_0000, 32'sh0001_0000, 32'sh0030_0000,
                  1'b1, 2'd3, 32'sh0030_0000};
        vt[2] = '{"tie_low_wins", 4'b0011, 32'sh0040_0000, 32'sh0040_0000, 32'sh0001_0000, 32'sh0001_0000,
                  1'b1, 2'd0, 32'sh0040_0000};
        vt[3] = '{"no_hits", 4'b0000, 32'sh0001_0000, 32'sh0002_0000, 32'sh0003_0000, 32'sh0004_0000,
                  1'b0, 2'd0, T_MAX};
`ifdef NEAR_CLIP_EN
        vt[4] = '{"behind_origin", 4'b0001, 32'shFFF0_0000, 32'sh0, 32'sh0, 32'sh0,
                  1'b0, 2'd0, T_MAX};
`else
        vt[4] = '{"behind_origin", 4'b0001, 32'shFFF0_0000, 32'sh0, 32'sh0, 32'sh0,
                  1'b1, 2'd0, 32'shFFF0_0000};
`endif
        vt[5] = '{"all_decreasing", 4'b1111, 32'sh0040_0000, 32'sh0030_0000, 32'sh0020_0000, 32'sh0010_0000,
                  1'b1, 2'd3, 32'sh0010_0000};
        vt[6] = '{"tie_with_tmax", 4'b0001, T_MAX, 32'sh0, 32'sh0, 32'sh0,
                  1'b0, 2'd0, T_MAX};

        Reset = 1'b1; start = 1'b0; ray = '0; cmask = '0;
        for (int i = 0; i < N; i++) ttab[i] = '0;
        load_mem();
        repeat (3) @(negedge Clk);
        chk("rst.busy", 128'(busy), 128'(0));
        chk("rst.done", 128'(done), 128'(0));
        chk("rst.sph_rd", 128'(sph_rd), 128'(0));
        chk("rst.sph_addr", 128'(sph_addr), 128'(0));
        chk("rst.hit", 128'(hit), 128'(0));
        chk("rst.hit_idx", 128'(hit_idx), 128'(0));
        chk("rst.hit_t", 128'(hit_t), 128'(T_MAX));
        chk("rst.col_tbest", 128'(col_tbest), 128'(T_MAX));
        chk("rst.col_ray", 128'(col_ray), 128'(0));
        chk("rst.col_sphere", 128'(col_sphere), 128'(0));
        Reset = 1'b0;

        // Directed table: table expectations checked against both the fixed values and the reference
        for (int v = 0; v < 7; v++) begin
            logic eh; logic [1:0] ei; fixed_real et, etb3;
            cmask = vt[v].cm;
            ttab[0] = vt[v].t0; ttab[1] = vt[v].t1; ttab[2] = vt[v].t2; ttab[3] = vt[v].t3;
            load_mem();
            ref_scan(eh, ei, et, etb3);
            run_and_check(vt[v].name);
            chk({vt[v].name, ".tbl_hit"}, 128'(hit), 128'(vt[v].eh));
            chk({vt[v].name, ".tbl_idx"}, 128'(hit_idx), 128'(vt[v].ei));
            chk({vt[v].name, ".tbl_t"}, 128'(hit_t), 128'(vt[v].et));
            if (v == 1) chk("nearer_later.tbest_spec", 128'(etb3), 128'(32'sh0080_0000));
        end

        // Randomized scans
        for (int r = 0; r < 24; r++) begin
            cmask = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: ttab[i] = 32'sh0040_0000;
                    1: ttab[i] = 32'sh0020_0000;
                    2: ttab[i] = 32'shFFF0_0000;
                    default: ttab[i] = fixed_real'($urandom);
                endcase
            end
            load_mem();
            run_and_check($sformatf("rand%0d", r));
        end

        // Reset in cycle 5 of a scan, with a simultaneous start that must be ignored
        cmask = 4'b0001; ttab[0] = 32'sh0010_0000; ttab[1] = '0; ttab[2] = '0; ttab[3] = '0;
        load_mem();
        @(negedge Clk); ray = rvec(); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        begin
            int nd;
            nd = 0;
            for (int c = 2; c <= 5; c++) begin
                @(negedge Clk);
                if (done) nd++;
            end
            chk("abort.hit_before", 128'(hit), 128'(1));
            Reset = 1'b1; start = 1'b1;
            @(negedge Clk);
            Reset = 1'b0; start = 1'b0;
            chk("abort.busy", 128'(busy), 128'(0));
            chk("abort.done", 128'(done), 128'(0));
            chk("abort.sph_rd", 128'(sph_rd), 128'(0));
            chk("abort.sph_addr", 128'(sph_addr), 128'(0));
            chk("abort.hit", 128'(hit), 128'(0));
            chk("abort.hit_idx", 128'(hit_idx), 128'(0));
            chk("abort.hit_t", 128'(hit_t), 128'(T_MAX));
            chk("abort.col_tbest", 128'(col_tbest), 128'(T_MAX));
            chk("abort.col_ray", 128'(col_ray), 128'(0));
            chk("abort.col_sphere", 128'(col_sphere), 128'(0));
            for (int c = 0; c < 16; c++) begin
                @(negedge Clk);
                if (done || busy) nd++;
            end
            chk("abort.no_done", 128'(nd), 128'(0));
        end

        // Scanner still works after the abort
        run_and_check("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
